// File: rtl/ahb_ifetch_if.sv
// ahb_ifetch_if: AHB-Lite read-only instruction bus between the fetch master and the slave side
// Signals:
//   HADDR  [31:0] master->slave  address-phase address
//   HTRANS [1:0]  master->slave  IDLE (00) or NONSEQ (10)
//   HWRITE        master->slave  always 0
//   HSIZE  [2:0]  master->slave  always word (010)
//   HREADY        slave->master  transfer done / bus ready
//   HRESP         slave->master  1 = ERROR
//   HRDATA [31:0] slave->master  read data
interface ahb_ifetch_if;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;
   modport master (output HADDR, HTRANS, HWRITE, HSIZE, input HREADY, HRESP, HRDATA);
   modport slave  (input HADDR, HTRANS, HWRITE, HSIZE, output HREADY, HRESP, HRDATA);
endinterface

// File: rtl/ahb_ifetch_master.sv
// ahb_ifetch_master: AHB-Lite read-only master fetching 32-bit instruction words into a prefetch FIFO
// Ports:
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   bus (master modport) AHB-Lite instruction bus
//   i_redirect           one-cycle pulse: flush and restart fetching at i_redirect_pc
//   i_redirect_pc [31:0] new fetch PC, bits [1:0] ignored
//   o_inst_valid         FIFO head valid (show-ahead)
//   o_inst [31:0]        instruction at FIFO head (0 for an error entry)
//   o_inst_pc [31:0]     PC of o_inst
//   o_inst_err           head entry returned an ERROR response
//   i_inst_ready         head consumed when o_inst_valid & i_inst_ready
module ahb_ifetch_master #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   ahb_ifetch_if.master bus,
   input  logic         i_redirect,
   input  logic [31:0]  i_redirect_pc,
   output logic         o_inst_valid,
   output logic [31:0]  o_inst,
   output logic [31:0]  o_inst_pc,
   output logic         o_inst_err,
   input  logic         i_inst_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic {RUN, HALT} state_t;
   state_t r_state, w_state_n;
   logic                  r_addr_valid, r_addr_stale, r_dp_valid, r_dp_stale;
   logic [31:0]           r_haddr, r_fetch_pc, r_dp_pc;
   logic [31:0]           r_mem_data [FIFO_DEPTH];
   logic [31:0]           r_mem_pc [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] r_mem_err;
   logic [AW-1:0]         r_wr, r_rd;
   logic [CW-1:0]         r_count, w_count_n;
   logic                  w_err1, w_hold, w_accept, w_push, w_pop, w_dp_n, w_issue;
   logic [31:0]           w_pc_n;
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) r_state <= RUN;
      else r_state <= w_state_n;
   always_comb begin
      // first cycle of a two-cycle ERROR response
      w_err1    = r_dp_valid & ~bus.HREADY & bus.HRESP;
      // a pending address phase must stay on the bus until HREADY, except when an error lets us cancel it
      w_hold    = r_addr_valid & ~bus.HREADY & ~w_err1;
      w_accept  = r_addr_valid & bus.HREADY;
      w_push    = r_dp_valid & bus.HREADY & ~r_dp_stale & ~i_redirect;
      w_pop     = o_inst_valid & i_inst_ready & ~i_redirect;
      w_state_n = i_redirect ? RUN : (w_err1 & ~r_dp_stale) ? HALT : r_state;
      // fetch_pc always equals the address of a live pending phase; stale phases do not advance it
      w_pc_n    = i_redirect ? (i_redirect_pc & ~32'd3) :
                  (w_accept & ~r_addr_stale) ? r_fetch_pc + 32'd4 : r_fetch_pc;
      w_count_n = i_redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
      // live beat occupying the data phase next cycle; stale beats hold no credit
      w_dp_n    = ~i_redirect & (bus.HREADY ? w_accept & ~r_addr_stale : r_dp_valid & ~r_dp_stale);
      w_issue   = (w_state_n == RUN) & ~w_err1 & ~w_hold &
                  ((w_count_n + CW'(w_dp_n)) < CW'(FIFO_DEPTH));
   end
   always_ff @(posedge HCLK or negedge HRESETn)
      if (!HRESETn) begin
         r_haddr      <= RESET_PC;
         r_fetch_pc   <= RESET_PC;
         r_addr_valid <= 1'b0;
         r_addr_stale <= 1'b0;
         r_dp_valid   <= 1'b0;
         r_dp_stale   <= 1'b0;
         r_dp_pc      <= '0;
         r_wr         <= '0;
         r_rd         <= '0;
         r_count      <= '0;
      end else begin
         r_fetch_pc   <= w_pc_n;
         r_addr_valid <= w_hold | w_issue;
         r_addr_stale <= w_hold & (r_addr_stale | i_redirect);
         if (w_issue) r_haddr <= w_pc_n;
         if (bus.HREADY) begin
            r_dp_valid <= r_addr_valid;
            r_dp_pc    <= r_haddr;
            r_dp_stale <= r_addr_stale | i_redirect;
         end else r_dp_stale <= r_dp_stale | i_redirect;
         r_count <= w_count_n;
         if (i_redirect) begin
            r_wr <= '0;
            r_rd <= '0;
         end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
         end
      end
   always_ff @(posedge HCLK)
      if (w_push) begin
         r_mem_data[r_wr] <= bus.HRESP ? 32'd0 : bus.HRDATA;
         r_mem_pc[r_wr]   <= r_dp_pc;
         r_mem_err[r_wr]  <= bus.HRESP;
      end
   assign bus.HADDR    = r_haddr;
   assign bus.HTRANS   = r_addr_valid ? 2'b10 : 2'b00;
   assign bus.HWRITE   = 1'b0;
   assign bus.HSIZE    = 3'b010;
   assign o_inst_valid = r_count != '0;
   assign o_inst       = o_inst_valid ? r_mem_data[r_rd] : 32'd0;
   assign o_inst_pc    = o_inst_valid ? r_mem_pc[r_rd] : 32'd0;
   assign o_inst_err   = o_inst_valid & r_mem_err[r_rd];
endmodule

// File: tb/tb_ahb_ifetch_master.sv
// tb_ahb_ifetch_master: randomized self-checking bench for ahb_ifetch_master with an AHB ROM slave model
module tb_ahb_ifetch_master;
   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = 32'd0;
   logic        i_inst_ready = 1'b0;
   logic        o_inst_valid, o_inst_err;
   logic [31:0] o_inst, o_inst_pc;
   int n_cmp = 0, n_bad = 0;
   int n_acc = 0, n_ns = 0, ns0;
   int min_wait = 0, max_wait = 0;
   logic [31:0] err_addr = 32'h1;
   logic [1:0]  p_trans = 2'b00;
   logic [31:0] p_addr = 32'd0;
   logic        p_ready = 1'b1, p_resp = 1'b0;
   logic [31:0] exp_pc = 32'd0;
   logic        halted = 1'b0, flush_chk = 1'b0;
   logic [31:0] pop_log [$];
   ahb_ifetch_if bus ();
   ahb_ifetch_master #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
      .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
      .o_inst_err(o_inst_err), .i_inst_ready(i_inst_ready));
   always #5 HCLK = ~HCLK;
   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic redirect(input logic [31:0] pc);
      i_redirect = 1'b1;
      i_redirect_pc = pc;
      @(posedge HCLK); #1;
      i_redirect = 1'b0;
   endtask
   task automatic wait_pops(input int n, input string tag);
      int t = 0;
      while (pop_log.size() < n && t < 400) begin
         @(posedge HCLK); #1;
         t++;
      end
      chk(tag, 32'(pop_log.size() >= n), 32'd1);
   endtask
   // ROM slave: one data phase at a time, optional wait states, two-cycle ERROR at err_addr
   initial begin
      bit          sl_dp = 1'b0;
      logic [31:0] sl_addr = 32'd0;
      int          sl_wait = 0, sl_err = 0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      bus.HRDATA = 32'd0;
      forever begin
         @(posedge HCLK); #1;
         if (!HRESETn) begin
            sl_dp = 1'b0;
            sl_err = 0;
         end else begin
            if (sl_dp && p_ready) sl_dp = 1'b0;
            if (p_ready && p_trans == 2'b10) begin
               sl_dp = 1'b1;
               sl_addr = p_addr;
               sl_wait = $urandom_range(max_wait, min_wait);
               sl_err = (p_addr == err_addr) ? 2 : 0;
            end
         end
         if (!sl_dp) begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'd0;
         end else if (sl_err == 2) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b1; sl_err = 1;
         end else if (sl_err == 1) begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b1; bus.HRDATA = rom(sl_addr); sl_err = 0;
         end else if (sl_wait > 0) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b0; sl_wait--;
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = rom(sl_addr);
         end
      end
   end
   // Monitor and reference model: the core must see an unbroken PC stream from the last redirect
   always @(negedge HCLK) begin
      if (HRESETn) begin
         if (p_trans == 2'b10 && !p_ready && !p_resp) begin
            chk("hold_htrans", 32'(bus.HTRANS), 32'(p_trans));
            chk("hold_haddr", bus.HADDR, p_addr);
         end
         if (!p_ready && p_resp) chk("err_idle", 32'(bus.HTRANS), 32'd0);
         if (bus.HTRANS == 2'b10) begin
            n_ns++;
            if (bus.HREADY) n_acc++;
            chk("haddr_align", 32'(bus.HADDR[1:0]), 32'd0);
         end
         if (flush_chk) begin
            chk("flush_empty", 32'(o_inst_valid), 32'd0);
            flush_chk = 1'b0;
         end
         if (i_redirect) begin
            exp_pc = i_redirect_pc & ~32'd3;
            halted = 1'b0;
            flush_chk = 1'b1;
            pop_log.delete();
         end else if (o_inst_valid && i_inst_ready) begin
            if (halted) chk("pop_after_halt", 32'(o_inst_valid), 32'd0);
            else begin
               chk("inst_pc", o_inst_pc, exp_pc);
               chk("inst_err", 32'(o_inst_err), 32'(exp_pc == err_addr));
               chk("inst_data", o_inst, (exp_pc == err_addr) ? 32'd0 : rom(exp_pc));
               pop_log.push_back(o_inst_pc);
               halted = (exp_pc == err_addr);
               exp_pc = exp_pc + 32'd4;
            end
         end
         p_trans = bus.HTRANS;
         p_addr  = bus.HADDR;
         p_ready = bus.HREADY;
         p_resp  = bus.HRESP;
      end else begin
         exp_pc = 32'd0;
         halted = 1'b0;
         flush_chk = 1'b0;
         pop_log.delete();
         p_trans = 2'b00;
         p_ready = 1'b1;
         p_resp = 1'b0;
      end
   end
   initial begin
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("rst_haddr", bus.HADDR, 32'd0);
      chk("rst_valid", 32'(o_inst_valid), 32'd0);
      chk("rst_inst", o_inst, 32'd0);
      chk("rst_pc", o_inst_pc, 32'd0);
      chk("rst_err", 32'(o_inst_err), 32'd0);
      chk("hwrite", 32'(bus.HWRITE), 32'd0);
      chk("hsize", 32'(bus.HSIZE), 32'd2);
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      chk("first_htrans", 32'(bus.HTRANS), 32'h2);
      chk("first_haddr", bus.HADDR, 32'd0);
      @(posedge HCLK); #1;
      chk("lat_valid0", 32'(o_inst_valid), 32'd0);
      @(posedge HCLK); #1;
      chk("lat_valid1", 32'(o_inst_valid), 32'd1);
      chk("lat_pc", o_inst_pc, 32'd0);
      repeat (10) @(posedge HCLK);
      #1;
      chk("full_accepted", 32'(n_acc), 32'd4);
      chk("full_idle", 32'(bus.HTRANS), 32'd0);
      i_inst_ready = 1'b1;
      @(posedge HCLK); #1;
      i_inst_ready = 1'b0;
      repeat (6) @(posedge HCLK);
      #1;
      chk("refill_accepted", 32'(n_acc), 32'd5);
      i_inst_ready = 1'b1;
      repeat (8) @(posedge HCLK);
      #1;
      ns0 = n_ns;
      repeat (20) @(posedge HCLK);
      #1;
      chk("b2b_nonseq", 32'(n_ns - ns0), 32'd20);
      redirect(32'h0000_0100);
      wait_pops(1, "redir_pops");
      if (pop_log.size() > 0) chk("redir_first_pc", pop_log[0], 32'h100);
      min_wait = 1;
      max_wait = 1;
      redirect(32'h0000_0200);
      wait_pops(32, "ws_pops");
      if (pop_log.size() > 31) chk("ws_last_pc", pop_log[31], 32'h27C);
      min_wait = 0;
      max_wait = 0;
      err_addr = 32'h0C;
      redirect(32'h0);
      repeat (30) @(posedge HCLK);
      #1;
      chk("err_halted", 32'(halted), 32'd1);
      chk("err_pops", 32'(pop_log.size()), 32'd4);
      ns0 = n_ns;
      repeat (10) @(posedge HCLK);
      #1;
      chk("halt_no_fetch", 32'(n_ns - ns0), 32'd0);
      err_addr = 32'h1;
      redirect(32'h40);
      wait_pops(4, "resume_pops");
      if (pop_log.size() > 0) chk("resume_pc", pop_log[0], 32'h40);
      redirect(32'hFFFF_FFFE);
      wait_pops(2, "wrap_pops");
      if (pop_log.size() > 1) begin
         chk("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
         chk("wrap_pc1", pop_log[1], 32'h0);
      end
      min_wait = 0;
      max_wait = 2;
      err_addr = 32'h5C;
      for (int c = 0; c < 3000; c++) begin
         i_inst_ready = ($urandom_range(0, 3) != 0);
         i_redirect = ($urandom_range(0, 24) == 0);
         i_redirect_pc = {24'h0, 8'($urandom)};
         @(posedge HCLK); #1;
      end
      i_redirect = 1'b0;
      i_inst_ready = 1'b1;
      #2 HRESETn = 1'b0;
      #1;
      chk("arst_htrans", 32'(bus.HTRANS), 32'd0);
      chk("arst_haddr", bus.HADDR, 32'd0);
      chk("arst_valid", 32'(o_inst_valid), 32'd0);
      repeat (2) @(posedge HCLK);
      #2 HRESETn = 1'b1;
      wait_pops(3, "post_rst_pops");
      if (pop_log.size() > 0) chk("post_rst_pc", pop_log[0], 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
